// File: rtl/rgmii_rx_delay_cal.sv
// RGMII receive delay calibration: sweeps every delay tap, scores IDDR preamble samples and
// loads the centre of the widest good window. Optional RGMII_RX_DELAY_CAL_STATS_EN adds tap_good_map.
module rgmii_rx_delay_cal #(
  parameter int TAP_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024,
  parameter int MIN_HITS      = 8,
  parameter int DEFAULT_TAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0]             rx_q1,
  input  logic [4:0]             rx_q2,
  output logic                   dly_ld,
  output logic [TAP_WIDTH-1:0]   dly_cntvalue,
  output logic                   busy,
  output logic                   done,
  output logic                   locked,
  output logic [TAP_WIDTH-1:0]   eye_start,
  output logic [TAP_WIDTH:0]     eye_width
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
  ,
  output logic [(2**TAP_WIDTH)-1:0] tap_good_map
`endif
);

  localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HIT_W   = $clog2(MIN_HITS + 1);

  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [HIT_W-1:0]     HIT_SAT     = HIT_W'(MIN_HITS);
  localparam logic [HIT_W-1:0]     HIT_ONE     = HIT_W'(1);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = {TAP_WIDTH{1'b1}};
  localparam logic [TAP_WIDTH-1:0] TAP_ONE     = TAP_WIDTH'(1);
  localparam logic [TAP_WIDTH-1:0] TAP_DEFAULT = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [TAP_WIDTH:0]   LEN_ONE     = (TAP_WIDTH+1)'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DWELL  = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_FINAL  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]           state_r;
  logic [TAP_WIDTH-1:0] tap_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [HIT_W-1:0]     hits_r;
  logic                 err_r;
  logic [TAP_WIDTH:0]   run_len_r;
  logic [TAP_WIDTH-1:0] run_start_r;
  logic [TAP_WIDTH:0]   best_len_r;
  logic [TAP_WIDTH-1:0] best_start_r;

  logic                 tap_good_s;
  logic [TAP_WIDTH:0]   run_len_s;
  logic [TAP_WIDTH-1:0] run_start_s;
  logic [TAP_WIDTH:0]   best_len_s;
  logic [TAP_WIDTH-1:0] best_start_s;
  logic [TAP_WIDTH-1:0] final_tap_s;
  logic                 preamble_s;
  logic                 error_s;

  function automatic logic is_preamble(input logic [4:0] q1, input logic [4:0] q2);
    return (q1 == 5'h15) && (q2 == 5'h15);
  endfunction

  // A falling-edge SFD nibble (D) after a rising-edge preamble nibble is legal, anything else is not.
  function automatic logic is_error(input logic [4:0] q1, input logic [4:0] q2);
    return (q1[4] != q2[4]) ||
           (q1[4] && q2[4] && (q1[3:0] == 4'h5) && (q2[3:0] != 4'h5) && (q2[3:0] != 4'hD));
  endfunction

  // Per-cycle scoring and end-of-tap window bookkeeping.
  always_comb begin
    preamble_s = is_preamble(rx_q1, rx_q2);
    error_s    = is_error(rx_q1, rx_q2);
    tap_good_s = (hits_r >= HIT_SAT) && !err_r;
    if (tap_good_s) begin
      run_len_s = run_len_r + LEN_ONE;
      if (run_len_r == '0) begin
        run_start_s = tap_r;
      end else begin
        run_start_s = run_start_r;
      end
    end else begin
      run_len_s   = '0;
      run_start_s = run_start_r;
    end
    if (run_len_s > best_len_r) begin
      best_len_s   = run_len_s;
      best_start_s = run_start_s;
    end else begin
      best_len_s   = best_len_r;
      best_start_s = best_start_r;
    end
    if (best_len_s != '0) begin
      final_tap_s = best_start_s + TAP_WIDTH'(best_len_s >> 1);
    end else begin
      final_tap_s = TAP_DEFAULT;
    end
  end

  // Calibration sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tap_r        <= '0;
      cnt_r        <= '0;
      hits_r       <= '0;
      err_r        <= 1'b0;
      run_len_r    <= '0;
      run_start_r  <= '0;
      best_len_r   <= '0;
      best_start_r <= '0;
      dly_ld       <= 1'b0;
      dly_cntvalue <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      locked       <= 1'b0;
      eye_start    <= '0;
      eye_width    <= '0;
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
      tap_good_map <= '0;
`endif
    end else begin
      dly_ld <= 1'b0;
      done   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_LOAD;
            busy         <= 1'b1;
            locked       <= 1'b0;
            tap_r        <= '0;
            run_len_r    <= '0;
            run_start_r  <= '0;
            best_len_r   <= '0;
            best_start_r <= '0;
            dly_ld       <= 1'b1;
            dly_cntvalue <= '0;
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
            tap_good_map <= '0;
`endif
          end
        end
        ST_LOAD: begin
          state_r <= ST_SETTLE;
          cnt_r   <= '0;
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_r <= ST_DWELL;
            cnt_r   <= '0;
            hits_r  <= '0;
            err_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DWELL: begin
          if (preamble_s && (hits_r < HIT_SAT)) begin
            hits_r <= hits_r + HIT_ONE;
          end
          if (error_s) begin
            err_r <= 1'b1;
          end
          if (cnt_r == DWELL_LAST) begin
            state_r <= ST_EVAL;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_EVAL: begin
          run_len_r    <= run_len_s;
          run_start_r  <= run_start_s;
          best_len_r   <= best_len_s;
          best_start_r <= best_start_s;
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
          tap_good_map[tap_r] <= tap_good_s;
`endif
          dly_ld <= 1'b1;
          if (tap_r == TAP_MAX) begin
            state_r      <= ST_FINAL;
            dly_cntvalue <= final_tap_s;
            locked       <= (best_len_s != '0);
            eye_start    <= (best_len_s != '0) ? best_start_s : '0;
            eye_width    <= best_len_s;
          end else begin
            state_r      <= ST_LOAD;
            tap_r        <= tap_r + TAP_ONE;
            dly_cntvalue <= tap_r + TAP_ONE;
          end
        end
        ST_FINAL: begin
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Bench for rgmii_rx_delay_cal: table-driven tap masks plus random masks scored by a
// rule-level reference model. Shortened settle/dwell lengths keep full sweeps cheap.
module tb_rgmii_rx_delay_cal;
  localparam int TW    = 5;
  localparam int NT    = 32;
  localparam int S     = 4;
  localparam int D     = 32;
  localparam int MH    = 8;
  localparam int DEF   = 0;
  localparam int TPT   = 1 + S + D + 1;
  localparam int SWEEP = NT * TPT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    rx_q1 = 5'h00;
  logic [4:0]    rx_q2 = 5'h00;
  logic          dly_ld;
  logic [TW-1:0] dly_cntvalue;
  logic          busy;
  logic          done;
  logic          locked;
  logic [TW-1:0] eye_start;
  logic [TW:0]   eye_width;
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
  logic [NT-1:0] tap_good_map;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0]  tq1 [NT][S+D];
  logic [4:0]  tq2 [NT][S+D];
  logic [31:0] gm;

  typedef struct {
    logic [31:0] mask;
    int          mode;
    logic        lk;
    logic [4:0]  st;
    logic [5:0]  w;
    logic [4:0]  tp;
    logic        repulse;
  } vec_t;

  vec_t vecs [10];

  rgmii_rx_delay_cal #(
    .TAP_WIDTH(TW), .SETTLE_CYCLES(S), .DWELL_CYCLES(D), .MIN_HITS(MH), .DEFAULT_TAP(DEF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_q1(rx_q1), .rx_q2(rx_q2),
    .dly_ld(dly_ld), .dly_cntvalue(dly_cntvalue), .busy(busy), .done(done),
    .locked(locked), .eye_start(eye_start), .eye_width(eye_width)
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
    , .tap_good_map(tap_good_map)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle that is neither a preamble hit nor an error.
  function automatic logic [9:0] quiet_cycle();
    logic [3:0] d1 = 4'($urandom);
    logic [3:0] d2 = 4'($urandom);
    if (d1 == 4'h5) d1 = 4'h6;
    case ($urandom_range(3))
      0:       return 10'h000;
      1:       return {5'h15, 5'h1D};
      2:       return {1'b1, d1, 1'b1, d2};
      default: return {1'b0, d1, 1'b0, d2};
    endcase
  endfunction

  function automatic logic [9:0] error_cycle();
    logic [3:0] d1 = 4'($urandom);
    logic [3:0] d2 = 4'($urandom);
    if (d2 == 4'h5 || d2 == 4'hD) d2 = 4'h0;
    case ($urandom_range(2))
      0:       return {1'b1, d1, 1'b0, d2};
      1:       return {1'b0, d1, 1'b1, d2};
      default: return {5'h15, 1'b1, d2};
    endcase
  endfunction

  // kinds: 0 good mixed, 1 exactly MH hits, 2 one error, 3 MH-1 hits, 4 ctl mismatch, 5 silent, 6 pure preamble
  task automatic gen_tap(input int t, input int kind);
    int nforce;
    for (int i = 0; i < S + D; i++) {tq1[t][i], tq2[t][i]} = 10'($urandom);
    for (int i = S; i < S + D; i++) begin
      case (kind)
        0, 2:    {tq1[t][i], tq2[t][i]} = ($urandom_range(1) == 1) ? {5'h15, 5'h15} : quiet_cycle();
        1, 3:    {tq1[t][i], tq2[t][i]} = quiet_cycle();
        4:       {tq1[t][i], tq2[t][i]} = {5'h15, 5'h05};
        5:       {tq1[t][i], tq2[t][i]} = 10'h000;
        default: {tq1[t][i], tq2[t][i]} = {5'h15, 5'h15};
      endcase
    end
    nforce = (kind == 3) ? MH - 1 : ((kind <= 2) ? MH : 0);
    for (int k = 0; k < nforce; k++) {tq1[t][S + k*(D/MH)], tq2[t][S + k*(D/MH)]} = {5'h15, 5'h15};
    if (kind == 2) begin
      int idx = S + $urandom_range(D - 1);
      {tq1[t][idx], tq2[t][idx]} = error_cycle();
    end
  endtask

  task automatic build(input logic [31:0] mask, input int mode);
    for (int t = 0; t < NT; t++) begin
      case (mode)
        0:       gen_tap(t, mask[t] ? 6 : 4);
        1:       gen_tap(t, mask[t] ? $urandom_range(1) : 2 + $urandom_range(3));
        2:       gen_tap(t, 5);
        default: gen_tap(t, mask[t] ? 1 : 3);
      endcase
    end
  endtask

  // Reference: a tap is good when its dwell samples hold >= MH preambles and no error cycle.
  function automatic logic tap_good_model(input int t);
    int hits = 0;
    logic err = 1'b0;
    for (int i = S; i < S + D; i++) begin
      logic [4:0] a = tq1[t][i];
      logic [4:0] b = tq2[t][i];
      if (a == 5'h15 && b == 5'h15) hits++;
      if (a[4] != b[4]) err = 1'b1;
      if (a[4] && b[4] && a[3:0] == 4'h5 && !(b[3:0] == 4'h5 || b[3:0] == 4'hD)) err = 1'b1;
    end
    return (hits >= MH) && !err;
  endfunction

  task automatic model_window(input logic [31:0] g, output logic lk, output logic [4:0] st,
                              output logic [5:0] w, output logic [4:0] tp);
    int best_s = 0;
    int best_l = 0;
    int l;
    for (int s = 0; s < NT; s++) begin
      if (g[s] && (s == 0 || !g[s-1])) begin
        l = 0;
        while (s + l < NT && g[s+l]) l++;
        if (l > best_l) begin
          best_l = l;
          best_s = s;
        end
      end
    end
    lk = (best_l > 0);
    st = (best_l > 0) ? 5'(best_s) : 5'd0;
    w  = 6'(best_l);
    tp = (best_l > 0) ? 5'(best_s + best_l / 2) : 5'(DEF);
  endtask

  task automatic drive(input int c);
    int t = c / TPT;
    int ph = c % TPT;
    if (c < SWEEP && ph >= 1 && ph <= S + D) begin
      rx_q1 = tq1[t][ph-1];
      rx_q2 = tq2[t][ph-1];
    end else begin
      {rx_q1, rx_q2} = 10'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input logic lk, input logic [4:0] st,
                           input logic [5:0] w, input logic [4:0] tp, input logic repulse);
    int lds = 0;
    int bad_ld = 0;
    int bad_st = 0;
    logic exp_ld;
    logic [4:0] exp_val;
    pulse_start();
    for (int c = 0; c < SWEEP + 2; c++) begin
      start = repulse && (c == 3 || c == 5*TPT + S + 3 || c == SWEEP + 1);
      drive(c);
      exp_ld  = (c < SWEEP) ? (c % TPT == 0) : (c == SWEEP);
      exp_val = (c < SWEEP) ? 5'(c / TPT) : tp;
      if (dly_ld !== exp_ld || (exp_ld && dly_cntvalue !== exp_val)) bad_ld++;
      if (busy !== 1'b1 || done !== 1'b0) bad_st++;
      if (dly_ld === 1'b1) lds++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({tag, "_ld_schedule"}, 64'(bad_ld), 64'd0);
    check({tag, "_busy_during"}, 64'(bad_st), 64'd0);
    check({tag, "_ld_count"}, 64'(lds), 64'd33);
    check({tag, "_done_busy"}, {done, busy, dly_ld}, 3'b100);
    check({tag, "_locked"}, 64'(locked), 64'(lk));
    check({tag, "_eye_start"}, 64'(eye_start), 64'(st));
    check({tag, "_eye_width"}, 64'(eye_width), 64'(w));
    check({tag, "_final_tap"}, 64'(dly_cntvalue), 64'(tp));
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
    check({tag, "_good_map"}, 64'(tap_good_map), 64'(gm));
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, {done, busy}, 2'b00);
    check({tag, "_tap_hold"}, 64'(dly_cntvalue), 64'(tp));
  endtask

  task automatic score_all();
    for (int t = 0; t < NT; t++) gm[t] = tap_good_model(t);
  endtask

  task automatic reset_mid();
    int bad = 0;
    pulse_start();
    for (int c = 0; c < 7*TPT + S + 11; c++) begin
      drive(c);
      @(posedge clk);
      #1;
    end
    check("abort_pre_busy", {busy, dly_cntvalue}, {1'b1, 5'd7});
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {dly_ld, dly_cntvalue, busy, done, locked, eye_start, eye_width}, 64'd0);
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
    check("abort_map", 64'(tap_good_map), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3*TPT; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || dly_ld !== 1'b0) bad++;
    end
    check("abort_no_done", 64'(bad), 64'd0);
  endtask

  initial begin
    logic lk;
    logic [4:0] st;
    logic [5:0] w;
    logic [4:0] tp;

    vecs[0] = '{32'h000FFC00, 0, 1'b1, 5'd10, 6'd10, 5'd15, 1'b1};
    vecs[1] = '{32'h00F0003C, 1, 1'b1, 5'd2,  6'd4,  5'd4,  1'b0};
    vecs[2] = '{32'h00000000, 2, 1'b0, 5'd0,  6'd0,  5'd0,  1'b0};
    vecs[3] = '{32'hFFFFFFFF, 1, 1'b1, 5'd0,  6'd32, 5'd16, 1'b0};
    vecs[4] = '{32'h80000000, 1, 1'b1, 5'd31, 6'd1,  5'd31, 1'b0};
    vecs[5] = '{32'h00000001, 1, 1'b1, 5'd0,  6'd1,  5'd0,  1'b0};
    vecs[6] = '{32'hC0000007, 1, 1'b1, 5'd0,  6'd3,  5'd1,  1'b0};
    vecs[7] = '{32'hE0000003, 1, 1'b1, 5'd29, 6'd3,  5'd30, 1'b0};
    vecs[8] = '{32'h000FC018, 1, 1'b1, 5'd14, 6'd6,  5'd17, 1'b0};
    vecs[9] = '{32'h0000FF00, 3, 1'b1, 5'd8,  6'd8,  5'd12, 1'b0};

    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {dly_ld, dly_cntvalue, busy, done, locked, eye_start, eye_width}, 64'd0);
`ifdef RGMII_RX_DELAY_CAL_STATS_EN
    check("reset_map", 64'(tap_good_map), 64'd0);
`endif
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", {busy, done, dly_ld}, 3'b000);

    for (int i = 0; i < 10; i++) begin
      build(vecs[i].mask, vecs[i].mode);
      score_all();
      run_sweep($sformatf("vec%0d", i), vecs[i].lk, vecs[i].st, vecs[i].w, vecs[i].tp, vecs[i].repulse);
    end

    for (int r = 0; r < 6; r++) begin
      logic [31:0] m = $urandom | $urandom;
      if (r == 0) m = $urandom & $urandom;
      build(m, 1);
      score_all();
      model_window(gm, lk, st, w, tp);
      run_sweep($sformatf("rand%0d", r), lk, st, w, tp, 1'b0);
    end

    build(vecs[0].mask, 0);
    score_all();
    reset_mid();
    run_sweep("after_abort", 1'b1, 5'd10, 6'd10, 5'd15, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_delay_cal.md
Name: rgmii_rx_delay_cal

Overview:
- Calibration controller for the RGMII receive input-delay/IDDR path.
- Sweeps every fixed-delay tap and scores the IDDR q1/q2 samples against preamble traffic at each tap.
- Finds the longest contiguous run of good taps, then loads the centre tap into the delay line.
- Sits beside the per-bit IDDR instances and drives their LD/CNTVALUEIN pins; reruns on request, e.g. after link-up.

Parameters:
- TAP_WIDTH, 5, width of delay tap value; sweep covers 0..2^TAP_WIDTH-1.
- SETTLE_CYCLES, 16, idle cycles after each tap load before scoring starts.
- DWELL_CYCLES, 1024, scoring cycles per tap.
- MIN_HITS, 8, preamble cycles a tap needs before it can count as good.
- DEFAULT_TAP, 0, tap loaded when no good tap exists.

Ports:
- clk  in  1  RX clock, same clock as the IDDR.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a calibration.
- rx_q1  in  5  IDDR rising-edge samples: {ctl, data[3:0]}.
- rx_q2  in  5  IDDR falling-edge samples: {ctl, data[3:0]}.
- dly_ld  out  1  one-cycle load strobe to the delay line.
- dly_cntvalue  out  TAP_WIDTH  tap value; valid while dly_ld is high and held afterwards.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when calibration ends.
- locked  out  1  at least one good window was found; held until the next start.
- eye_start  out  TAP_WIDTH  first tap of the chosen window.
- eye_width  out  TAP_WIDTH+1  length of the chosen window; 0 if none.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0. Reset takes effect mid-sweep too; the sweep aborts and no done pulse is issued.
- FSM states: IDLE -> LOAD -> SETTLE -> DWELL -> EVAL -> (LOAD | FINAL) -> DONE -> IDLE.
- IDLE: start=1 sets busy=1 the next cycle, tap=0, clears run/best registers, goes to LOAD. start is ignored in every other state.
- LOAD: dly_ld=1 for exactly 1 cycle with dly_cntvalue=tap, then SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then DWELL with both score counters cleared.
- DWELL, per-cycle scoring over DWELL_CYCLES cycles:
  - preamble cycle: q1.ctl=1, q2.ctl=1, q1.data=5, q2.data=5.
  - error cycle: q1.ctl != q2.ctl, OR (q1.ctl=q2.ctl=1 and q1.data=5 and q2.data not in {5, D}).
  - hit counter saturates at MIN_HITS. Error flag is sticky for the tap.
- EVAL, 1 cycle: good = (hits >= MIN_HITS) and no error.
  - Good tap: run_len+1, and run_start=tap if run_len was 0.
  - Bad tap: run_len=0.
  - After the update, if run_len > best_len (strictly greater), copy run_start/run_len into best; ties keep the earlier window.
  - If tap = 2^TAP_WIDTH-1, go to FINAL. Otherwise tap+1 and LOAD. There is no wrap-around, and a window never spans tap max->0.
- FINAL:
  - best_len > 0: tap = best_start + (best_len >> 1) (floor centre); locked=1; eye_start=best_start; eye_width=best_len.
  - best_len = 0: tap = DEFAULT_TAP; locked=0; eye_start=0; eye_width=0.
  - Pulses dly_ld 1 cycle with that tap, then DONE.
- DONE: done=1 for 1 cycle, busy=0 the same cycle, return to IDLE. dly_cntvalue holds the final tap.
- Latency for a full sweep: 2^TAP_WIDTH*(1+SETTLE_CYCLES+DWELL_CYCLES+1)+3 cycles from the start pulse to done.
- Counter width: clog2(DWELL_CYCLES+1). eye_width is TAP_WIDTH+1 bits so a fully good sweep (32) fits.

Optional Feature:
- Macro: RGMII_RX_DELAY_CAL_STATS_EN.
- Defined: adds output port tap_good_map [2^TAP_WIDTH-1:0]. Bit n is written in EVAL of tap n. The map clears on start and holds after done. Reset value is 0.
- Undefined: the port and its register do not exist. No other behaviour changes.

Test Plan:
- Stimulus model: good taps 10..19 get constant preamble {1,5}/{1,5}; every other tap gets q1.ctl=1, q2.ctl=0. Pulse start -> locked=1, eye_start=10, eye_width=10, final dly_cntvalue=15, exactly 33 dly_ld pulses, done after 32*1042+3 cycles.
- Two windows, taps 2..5 and 20..23 (equal length) -> eye_start=2, eye_width=4, final tap 4.
- No traffic (ctl=0 on all taps, so hits=0) -> locked=0, eye_width=0, final tap=DEFAULT_TAP=0, done still pulses.
- All taps good -> eye_start=0, eye_width=32, final tap 16.
- Assert rst during tap 7 DWELL -> busy=0 and all outputs 0 immediately; no done pulse; a new start then completes normally.
- start re-pulsed while busy -> ignored, sweep timing unchanged. With RGMII_RX_DELAY_CAL_STATS_EN, scenario 1 gives tap_good_map=32'h000FFC00.
